garage_gate_ctrl: RTL and testbench

Controller for the single shared lane gate of the car garage. It arbitrates entry and exit requests and opens the gate for the granted direction. When the car clears the lane, it issues a one-cycle increment or decrement to the occupancy up_counter. It reads the counter's count back to derive full and empty, and refuses entries when full and exits when empty.

---
 rtl/garage_pkg.sv | 25 ++
 rtl/garage_rr_arb.sv | 25 ++
 rtl/garage_gate_ctrl.sv | 133 +++++++++++++
 tb/tb_garage_gate_ctrl.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/garage_pkg.sv
// Shared definitions for the garage lane gate: FSM state codes, lane directions,
// default capacity and the round-robin pick rule used by the lane arbiter.
package garage_pkg;

   typedef logic [1:0] state_t;

   localparam state_t ST_IDLE  = 2'd0;
   localparam state_t ST_OPEN  = 2'd1;
   localparam state_t ST_CLOSE = 2'd2;

   localparam logic DIR_IN  = 1'b1;
   localparam logic DIR_OUT = 1'b0;

   localparam int CAPACITY_DEFAULT = 50;

   // With both sides wanting the lane, the side that did not go last wins.
   function automatic logic rr_pick(input logic want_in, input logic want_out,
                                    input logic last_grant);
      logic pick;
      if (want_in && want_out) pick = ~last_grant;
      else                     pick = want_in ? DIR_IN : DIR_OUT;
      return pick;
   endfunction

endpackage

// File: rtl/garage_rr_arb.sv
// Two-requester round-robin arbiter (entry vs exit) holding the last granted
// direction; reusable per lane.
module garage_rr_arb (
   input  logic clk,
   input  logic reset,
   input  logic req_in,
   input  logic req_out,
   input  logic enable,
   output logic grant,
   output logic grant_dir
);
   import garage_pkg::*;

   logic last_grant;

   assign grant     = req_in | req_out;
   assign grant_dir = rr_pick(req_in, req_out, last_grant);

   // EXIT as the reset history makes entry win the first tie.
   always_ff @(posedge clk) begin
      if (!reset)                last_grant <= DIR_OUT;
      else if (enable && grant)  last_grant <= grant_dir;
   end

endmodule

// File: rtl/garage_gate_ctrl.sv
// Lane gate controller: arbitrates entry/exit, drives the gate and emits
// occupancy pulses. Optional OPEN timeout: define GARAGE_GATE_TIMEOUT_EN.
module garage_gate_ctrl
   import garage_pkg::*;
#(
   parameter int CAPACITY       = CAPACITY_DEFAULT,
   parameter int CNT_W          = 6,
   parameter int CLOSE_CYCLES   = 4,
   parameter int TIMEOUT_CYCLES = 1000
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             entry_req,
   input  logic             exit_req,
   input  logic             pass_in,
   input  logic             pass_out,
   input  logic [CNT_W-1:0] count,
   output logic             gate_open,
   output logic             dir_in,
   output logic             increment,
   output logic             decrement,
   output logic             full,
   output logic             empty,
   output logic             deny,
   output logic             busy
);

   localparam int           CLOSE_W    = (CLOSE_CYCLES > 2) ? $clog2(CLOSE_CYCLES) : 1;
   localparam logic [CLOSE_W-1:0] CLOSE_LAST = CLOSE_W'(CLOSE_CYCLES - 1);

   if (CLOSE_CYCLES < 2 || TIMEOUT_CYCLES < 1 || (2 ** CNT_W) <= CAPACITY) begin : g_bad_cfg
      $error("garage_gate_ctrl: illegal parameter combination");
   end

   state_t             state;
   logic [CLOSE_W-1:0] close_cnt;
   logic               entry_ok, exit_ok, refused;
   logic               grant, grant_dir;
   logic               pass_match;
   logic               timeout;

   assign full    = (count >= CNT_W'(CAPACITY));
   assign empty   = (count == '0);
   assign busy    = (state != ST_IDLE);

   assign entry_ok   = entry_req && !full;
   assign exit_ok    = exit_req  && !empty;
   assign refused    = (entry_req && full) || (exit_req && empty);
   assign pass_match = dir_in ? pass_in : pass_out;

   garage_rr_arb u_arb (
      .clk       (clk),
      .reset     (reset),
      .req_in    (entry_ok),
      .req_out   (exit_ok),
      .enable    (state == ST_IDLE),
      .grant     (grant),
      .grant_dir (grant_dir)
   );

`ifdef GARAGE_GATE_TIMEOUT_EN
   localparam int TO_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

   logic [TO_W-1:0] to_cnt;

   // Counts OPEN cycles; the last allowed cycle without a matching pass closes.
   always_ff @(posedge clk) begin
      if (!reset)                to_cnt <= '0;
      else if (state == ST_OPEN) to_cnt <= to_cnt + 1'b1;
      else                       to_cnt <= '0;
   end

   assign timeout = (state == ST_OPEN) && (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));
`else
   assign timeout = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (!reset) begin
         state     <= ST_IDLE;
         gate_open <= 1'b0;
         dir_in    <= DIR_OUT;
         increment <= 1'b0;
         decrement <= 1'b0;
         deny      <= 1'b0;
         close_cnt <= '0;
      end else begin
         // NOTE: pulse outputs default low with non-blocking assignments so a later branch can raise them for exactly one cycle.
         increment <= 1'b0;
         decrement <= 1'b0;
         deny      <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (grant) begin
                  state     <= ST_OPEN;
                  gate_open <= 1'b1;
                  dir_in    <= grant_dir;
               end else begin
                  deny <= refused;
               end
            end
            ST_OPEN: begin
               if (pass_match) begin
                  // Boundary is re-checked so the counter can never wrap.
                  increment <= dir_in && !full;
                  decrement <= !dir_in && !empty;
                  state     <= ST_CLOSE;
                  gate_open <= 1'b0;
                  close_cnt <= '0;
               end else if (timeout) begin
                  state     <= ST_CLOSE;
                  gate_open <= 1'b0;
                  close_cnt <= '0;
               end
            end
            ST_CLOSE: begin
               if (close_cnt == CLOSE_LAST) begin
                  state     <= ST_IDLE;
                  close_cnt <= '0;
               end else begin
                  close_cnt <= close_cnt + 1'b1;
               end
            end
            default: begin
               state     <= ST_IDLE;
               gate_open <= 1'b0;
               close_cnt <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_garage_gate_ctrl.sv
// Self-checking bench for garage_gate_ctrl: directed scenarios plus random
// traffic against a behavioural lane model with an emulated occupancy counter.
module tb_garage_gate_ctrl;

   localparam int CAP    = 50;
   localparam int CNT_W  = 6;
   localparam int CLOSE  = 4;
   localparam int TO     = 8;
`ifdef GARAGE_GATE_TIMEOUT_EN
   localparam bit TO_EN = 1'b1;
`else
   localparam bit TO_EN = 1'b0;
`endif

   logic             clk = 1'b0;
   logic             reset, entry_req, exit_req, pass_in, pass_out;
   logic [CNT_W-1:0] count;
   logic             gate_open, dir_in, increment, decrement, full, empty, deny, busy;

   garage_gate_ctrl #(
      .CAPACITY(CAP), .CNT_W(CNT_W), .CLOSE_CYCLES(CLOSE), .TIMEOUT_CYCLES(TO)
   ) dut (
      .clk(clk), .reset(reset), .entry_req(entry_req), .exit_req(exit_req),
      .pass_in(pass_in), .pass_out(pass_out), .count(count),
      .gate_open(gate_open), .dir_in(dir_in), .increment(increment),
      .decrement(decrement), .full(full), .empty(empty), .deny(deny), .busy(busy)
   );

   always #5 clk = ~clk;

   int vectors = 0;
   int miscompares = 0;

   task automatic check(input string tag, input int got, input int exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   // Lane model: phase of the lane plus the few facts the rules refer to.
   typedef enum int {P_IDLE, P_OPEN, P_CLOSE} phase_t;
   phase_t m_phase = P_IDLE;
   bit     m_gate = 0, m_dir = 0, m_last = 0, m_inc = 0, m_dec = 0, m_deny = 0;
   int     m_age = 0, m_left = 0;
   int     occ = 0;

   int     dut_dirs[$];
   int     dut_gaps[$];
   bit     prev_gate = 0;
   int     low_run = 0;

   task automatic model_step(input bit rst, input bit e, input bit x,
                             input bit pi, input bit po);
      bit f, em, ee, xe, pick, hit;
      f  = (occ >= CAP);
      em = (occ == 0);
      m_inc = 0; m_dec = 0; m_deny = 0;
      if (!rst) begin
         m_phase = P_IDLE; m_gate = 0; m_dir = 0; m_last = 0; m_age = 0; m_left = 0;
         return;
      end
      case (m_phase)
         P_IDLE: begin
            ee = e && !f;
            xe = x && !em;
            if (ee || xe) begin
               pick    = (ee && xe) ? !m_last : ee;
               m_phase = P_OPEN; m_gate = 1; m_dir = pick; m_last = pick; m_age = 1;
            end else begin
               m_deny = (e && f) || (x && em);
            end
         end
         P_OPEN: begin
            hit = m_dir ? pi : po;
            if (hit) begin
               m_inc = m_dir && !f;
               m_dec = !m_dir && !em;
               m_phase = P_CLOSE; m_gate = 0; m_left = CLOSE;
            end else if (TO_EN && m_age == TO) begin
               m_phase = P_CLOSE; m_gate = 0; m_left = CLOSE;
            end else begin
               m_age++;
            end
         end
         default: begin
            m_left--;
            if (m_left == 0) m_phase = P_IDLE;
         end
      endcase
   endtask

   task automatic cycle(input bit rst, input bit e, input bit x, input bit pi, input bit po);
      @(negedge clk);
      // Emulated up_counter: a pulse seen last cycle lands on the next edge.
      if (m_inc) occ++;
      if (m_dec) occ--;
      reset = rst; entry_req = e; exit_req = x; pass_in = pi; pass_out = po;
      count = CNT_W'(occ);
      model_step(rst, e, x, pi, po);
      @(posedge clk);
      #1;
      check("gate_open", gate_open, m_gate);
      check("dir_in",    dir_in,    m_dir);
      check("increment", increment, m_inc);
      check("decrement", decrement, m_dec);
      check("deny",      deny,      m_deny);
      check("busy",      busy,      m_phase != P_IDLE);
      check("full",      full,      occ >= CAP);
      check("empty",     empty,     occ == 0);
      if (gate_open && !prev_gate) begin
         dut_dirs.push_back(dir_in);
         dut_gaps.push_back(low_run);
      end
      low_run   = gate_open ? 0 : low_run + 1;
      prev_gate = gate_open;
   endtask

   task automatic do_reset(input int n);
      for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0);
   endtask

   initial begin
      reset = 0; entry_req = 0; exit_req = 0; pass_in = 0; pass_out = 0; count = '0;

      // Reset, then a single entry with the pass on the 5th OPEN cycle.
      occ = 0;
      do_reset(2);
      for (int i = 0; i < 16; i++)
         cycle(1, i < 3, 0, m_phase == P_OPEN && m_dir && m_age == 5, 0);

      // Full: entries refused every IDLE cycle.
      do_reset(1);
      occ = CAP;
      for (int i = 0; i < 10; i++) cycle(1, 1, 0, 1, 0);

      // Empty: exits refused, never a decrement.
      occ = 0;
      for (int i = 0; i < 10; i++) cycle(1, 0, 1, 0, 1);

      // Both sides held: round-robin entry, exit, entry.
      do_reset(1);
      occ = 10;
      dut_dirs.delete();
      dut_gaps.delete();
      for (int i = 0; i < 40 && dut_dirs.size() < 3; i++)
         cycle(1, 1, 1, m_phase == P_OPEN && m_dir && m_age == 2,
                         m_phase == P_OPEN && !m_dir && m_age == 2);
      if (dut_dirs.size() < 3) begin
         check("rr_grant_count", dut_dirs.size(), 3);
      end else begin
         check("rr_grant0_dir", dut_dirs[0], 1);
         check("rr_grant1_dir", dut_dirs[1], 0);
         check("rr_grant2_dir", dut_dirs[2], 1);
         check("rr_gap1", dut_gaps[1], CLOSE + 1);
         check("rr_gap2", dut_gaps[2], CLOSE + 1);
      end
      for (int i = 0; i < 8; i++)
         cycle(1, 0, 0, m_phase == P_OPEN && m_dir, m_phase == P_OPEN && !m_dir);

      // Wrong-direction pass ignored, then reset mid-OPEN.
      do_reset(1);
      occ = 5;
      cycle(1, 1, 0, 0, 0);
      cycle(1, 0, 0, 0, 0);
      cycle(1, 0, 0, 0, 1);
      cycle(1, 0, 0, 0, 0);
      cycle(0, 0, 0, 1, 0);
      for (int i = 0; i < 3; i++) cycle(1, 0, 0, 1, 0);

      // Entry with no pass: times out when the feature is built in.
      cycle(1, 1, 0, 0, 0);
      for (int i = 0; i < TO + 4; i++) cycle(1, 0, 0, 0, 0);
      for (int i = 0; i < 3; i++) cycle(1, 0, 0, 1, 0);

      // Random traffic with occasional resets and occupancy jumps near the bounds.
      for (int i = 0; i < 2000; i++) begin
         bit rst, e, x, pi, po;
         if (m_phase == P_IDLE && !m_inc && !m_dec && $urandom_range(0, 15) == 0) begin
            case ($urandom_range(0, 4))
               0:       occ = 0;
               1:       occ = 1;
               2:       occ = CAP - 1;
               3:       occ = CAP;
               default: occ = $urandom_range(0, CAP);
            endcase
         end
         rst = ($urandom_range(0, 199) != 0);
         e   = ($urandom_range(0, 2) != 0);
         x   = ($urandom_range(0, 2) != 0);
         pi  = ($urandom_range(0, 3) == 0);
         po  = ($urandom_range(0, 3) == 0);
         cycle(rst, e, x, pi, po);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
